alu_8bit: RTL and testbench
===========================

# alu_8bit

8-bit combinational-datapath ALU with registered outputs and a pulse handshake. It accepts a 5-bit opcode, two 8-bit operands and carry/borrow inputs, and produces an 8-bit result plus five status flags. It sits behind a host/sequencer that loads operands and raises `input_ready`. The host then reads `result_out` and the flags one at a time.

## Interface
- Parameters: none (width fixed at 8, opcode width fixed at 5).
- One clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-low reset
- `opcode`  in  5  operation select
- `operand_A`  in  8  first operand
- `operand_B`  in  8  second operand
- `enable`  in  1  1 = operations accepted; 0 = block frozen
- `input_ready`  in  1  start request; level signal, edge-detected
- `carry_in`  in  1  carry for ADC
- `borrow_in`  in  1  borrow for SBB
- `result_out`  out  8  registered result
- `carry_out`  out  1  unsigned carry / shifted-out bit
- `borrow_out`  out  1  unsigned borrow
- `zero`  out  1  result == 0
- `negative`  out  1  result[7]
- `overflow`  out  1  signed overflow
- `result_ready`  out  1  one-cycle pulse when outputs update

## Operation
- **Launch condition:** `launch = input_ready & ~ir_q & enable`.
  - `ir_q` is `input_ready` registered every cycle, regardless of `enable`.
  - A level held high launches only once.
  - A rising edge while `enable=0` is lost.
- **Opcodes:**
  - 0x00 ADD: A+B
  - 0x01 ADC: A+B+cin
  - 0x02 SUB: A−B
  - 0x03 SBB: A−B−bin
  - 0x04 INC: A+1
  - 0x05 DEC: A−1
  - 0x06 AND
  - 0x07 OR
  - 0x08 XOR
  - 0x09 NOT A
  - 0x0A NAND
  - 0x0B NOR
  - 0x0C XNOR
  - 0x0D SHL A
  - 0x0E SHR A (logical)
  - 0x0F ASR A
  - 0x10 ROL A
  - 0x11 ROR A
  - 0x12 CMP: flags of A−B; `result_out` unchanged
  - 0x13 PASS A
  - 0x14 PASS B
  - 0x15 NEG: 0−A
  - 0x16–0x1F reserved: result 0, `zero`=1, other flags 0
- **Arithmetic:** computed at 9 bits.
  - `carry_out` = bit 8 for ADD/ADC/INC.
  - `borrow_out` = 1 when the unsigned minuend < subtrahend (+borrow) for SUB/SBB/DEC/CMP/NEG.
  - `overflow` = signed overflow for ADD/ADC/INC (same-sign operands, different-sign result) and for SUB/SBB/DEC/CMP/NEG (different-sign operands, result sign ≠ A).
- **Shifts and rotates:** `carry_out` = bit shifted/rotated out (A[7] for SHL/ROL, A[0] for SHR/ASR/ROR). `borrow_out` and `overflow` = 0.
- **Logic and pass ops:** `carry_out`, `borrow_out`, `overflow` = 0.
- **Flags from the result:** `zero` and `negative` always come from the computed result, including CMP's internal difference.
- Every launch updates all flags. Flags not defined for an op are cleared.

## Timing
- Inputs are sampled at the edge where `launch`=1.
  - `result_out` and flags are valid after that same edge (latency 1 clock).
  - `result_ready`=1 for exactly the following cycle.
- Outputs hold until the next launch or reset.
- Back-to-back launches need `input_ready` low for ≥1 sampled cycle between them, so the minimum spacing is 2 cycles.
- `enable=0`:
  - no launch;
  - outputs hold;
  - `result_ready`=0 from the next edge.
- **Reset** (`rst`=0 at an edge): `result_out`, all flags, `result_ready` and `ir_q` clear to 0.
  - Reset wins over a simultaneous launch.
  - After release, an `input_ready` that is already high does not launch until it drops and rises again.

## Structure
- `alu_pkg`: 5-bit opcode localparams (`OP_ADD` … `OP_NEG`) and the flag-vector typedef.
- One sub-module, `alu_datapath`:
  - purely combinational;
  - maps opcode/operands/cin/bin to next result and flags.
- The top holds the edge detector, output registers and `result_ready`.

## Test plan
- ADD A=0x7F B=0x01 → `result_out`=0x80, `negative`=1, `overflow`=1, `carry_out`=0, `zero`=0, `result_ready` pulses 1 cycle.
- ADD A=0xFF B=0x01 → 0x00, `carry_out`=1, `zero`=1. Then SBB A=0x00 B=0x00 bin=1 → 0xFF, `borrow_out`=1, `negative`=1.
- SHL A=0x81 → 0x02, `carry_out`=1. Then ROR A=0x01 → 0x80, `carry_out`=1, `negative`=1.
- CMP A=0x05 B=0x05 after a previous result 0x80 → `result_out` stays 0x80, `zero`=1, `borrow_out`=0. Opcode 0x1F → 0x00, `zero`=1, other flags 0.
- Hold `input_ready`=1 for 10 cycles → exactly one `result_ready` pulse.
- Raise `input_ready` with `enable`=0 → no pulse and outputs unchanged.
- Assert `rst`=0 in the launch cycle → all outputs 0 and no pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and status flag vector for alu_8bit
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_ADC  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_SBB  = 5'h03;
  localparam logic [4:0] OP_INC  = 5'h04;
  localparam logic [4:0] OP_DEC  = 5'h05;
  localparam logic [4:0] OP_AND  = 5'h06;
  localparam logic [4:0] OP_OR   = 5'h07;
  localparam logic [4:0] OP_XOR  = 5'h08;
  localparam logic [4:0] OP_NOT  = 5'h09;
  localparam logic [4:0] OP_NAND = 5'h0A;
  localparam logic [4:0] OP_NOR  = 5'h0B;
  localparam logic [4:0] OP_XNOR = 5'h0C;
  localparam logic [4:0] OP_SHL  = 5'h0D;
  localparam logic [4:0] OP_SHR  = 5'h0E;
  localparam logic [4:0] OP_ASR  = 5'h0F;
  localparam logic [4:0] OP_ROL  = 5'h10;
  localparam logic [4:0] OP_ROR  = 5'h11;
  localparam logic [4:0] OP_CMP  = 5'h12;
  localparam logic [4:0] OP_PASA = 5'h13;
  localparam logic [4:0] OP_PASB = 5'h14;
  localparam logic [4:0] OP_NEG  = 5'h15;

  typedef struct packed {
    logic carry;
    logic borrow;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - combinational next-result and flag generation
module alu_datapath
  import alu_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic [7:0] result,
  output alu_flags_t flags,
  output logic       result_write
);

  logic [7:0] x;
  logic [7:0] y;
  logic       cb;
  logic       is_add;
  logic       is_sub;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] res;
  logic       c;
  logic       bo;
  logic       v;

  // All arithmetic ops share one adder and one subtractor; NEG is 0 - A.
  always_comb begin
    x      = operand_a;
    y      = 8'h00;
    cb     = 1'b0;
    is_add = 1'b0;
    is_sub = 1'b0;
    case (opcode)
      OP_ADD:  begin y = operand_b; is_add = 1'b1; end
      OP_ADC:  begin y = operand_b; cb = carry_in; is_add = 1'b1; end
      OP_SUB:  begin y = operand_b; is_sub = 1'b1; end
      OP_SBB:  begin y = operand_b; cb = borrow_in; is_sub = 1'b1; end
      OP_INC:  begin y = 8'h01; is_add = 1'b1; end
      OP_DEC:  begin y = 8'h01; is_sub = 1'b1; end
      OP_CMP:  begin y = operand_b; is_sub = 1'b1; end
      OP_NEG:  begin x = 8'h00; y = operand_a; is_sub = 1'b1; end
      default: ;
    endcase
  end

  assign sum9  = {1'b0, x} + {1'b0, y} + {8'h00, cb};
  assign diff9 = {1'b0, x} - {1'b0, y} - {8'h00, cb};

  always_comb begin
    res = 8'h00;
    c   = 1'b0;
    bo  = 1'b0;
    v   = 1'b0;
    if (is_add) begin
      res = sum9[7:0];
      c   = sum9[8];
      v   = (x[7] == y[7]) && (res[7] != x[7]);
    end else if (is_sub) begin
      res = diff9[7:0];
      bo  = diff9[8];
      v   = (x[7] != y[7]) && (res[7] != x[7]);
    end else begin
      case (opcode)
        OP_AND:  res = operand_a & operand_b;
        OP_OR:   res = operand_a | operand_b;
        OP_XOR:  res = operand_a ^ operand_b;
        OP_NOT:  res = ~operand_a;
        OP_NAND: res = ~(operand_a & operand_b);
        OP_NOR:  res = ~(operand_a | operand_b);
        OP_XNOR: res = ~(operand_a ^ operand_b);
        OP_SHL:  begin res = {operand_a[6:0], 1'b0};         c = operand_a[7]; end
        OP_SHR:  begin res = {1'b0, operand_a[7:1]};         c = operand_a[0]; end
        OP_ASR:  begin res = {operand_a[7], operand_a[7:1]}; c = operand_a[0]; end
        OP_ROL:  begin res = {operand_a[6:0], operand_a[7]}; c = operand_a[7]; end
        OP_ROR:  begin res = {operand_a[0], operand_a[7:1]}; c = operand_a[0]; end
        OP_PASA: res = operand_a;
        OP_PASB: res = operand_b;
        default: res = 8'h00;
      endcase
    end
  end

  assign result         = res;
  assign flags.carry    = c;
  assign flags.borrow   = bo;
  assign flags.zero     = (res == 8'h00);
  assign flags.negative = res[7];
  assign flags.overflow = v;
  assign result_write   = (opcode != OP_CMP);

endmodule

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - 8-bit ALU with edge-detected launch and registered outputs
module alu_8bit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [7:0] operand_A,
  input  logic [7:0] operand_B,
  input  logic       enable,
  input  logic       input_ready,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic [7:0] result_out,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       zero,
  output logic       negative,
  output logic       overflow,
  output logic       result_ready
);

  logic       ir_q;
  logic       armed;
  logic       launch;
  logic [7:0] dp_result;
  alu_flags_t dp_flags;
  logic       dp_write;
  logic [7:0] result_q;
  alu_flags_t flags_q;

  alu_datapath u_datapath (
    .opcode       (opcode),
    .operand_a    (operand_A),
    .operand_b    (operand_B),
    .carry_in     (carry_in),
    .borrow_in    (borrow_in),
    .result       (dp_result),
    .flags        (dp_flags),
    .result_write (dp_write)
  );

  // armed blocks a launch from an input_ready level that was already high
  // across reset; it is set once input_ready has been seen low.
  assign launch = input_ready & ~ir_q & enable & armed;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_q         <= 1'b0;
      armed        <= ~input_ready;
      result_q     <= 8'h00;
      flags_q      <= '0;
      result_ready <= 1'b0;
    end else begin
      ir_q         <= input_ready;
      result_ready <= launch;
      if (!input_ready) begin
        armed <= 1'b1;
      end
      if (launch) begin
        flags_q <= dp_flags;
        if (dp_write) begin
          result_q <= dp_result;
        end
      end
    end
  end

  assign result_out = result_q;
  assign carry_out  = flags_q.carry;
  assign borrow_out = flags_q.borrow;
  assign zero       = flags_q.zero;
  assign negative   = flags_q.negative;
  assign overflow   = flags_q.overflow;

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - scoreboard bench for alu_8bit
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [7:0] operand_A;
  logic [7:0] operand_B;
  logic       enable;
  logic       input_ready;
  logic       carry_in;
  logic       borrow_in;
  logic [7:0] result_out;
  logic       carry_out;
  logic       borrow_out;
  logic       zero;
  logic       negative;
  logic       overflow;
  logic       result_ready;

  int checks = 0;
  int errors = 0;
  logic [12:0] sb_q[$];
  logic [12:0] last_exp;

  alu_8bit dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .operand_A    (operand_A),
    .operand_B    (operand_B),
    .enable       (enable),
    .input_ready  (input_ready),
    .carry_in     (carry_in),
    .borrow_in    (borrow_in),
    .result_out   (result_out),
    .carry_out    (carry_out),
    .borrow_out   (borrow_out),
    .zero         (zero),
    .negative     (negative),
    .overflow     (overflow),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] observed();
    return {result_out, carry_out, borrow_out, zero, negative, overflow};
  endfunction

  // Reference model in integer arithmetic: {shown_result, c, b, z, n, v}
  function automatic logic [12:0] model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic bi, input logic [7:0] prev);
    int ia, ib, sa, sb, r, sr;
    logic c, bo, v;
    logic [7:0] res, shown;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    c = 1'b0; bo = 1'b0; v = 1'b0; r = 0; sr = 0;
    case (op)
      5'h00: begin r = ia + ib;          sr = sa + sb;          c = (r > 255); end
      5'h01: begin r = ia + ib + int'(ci); sr = sa + sb + int'(ci); c = (r > 255); end
      5'h02: begin r = ia - ib;          sr = sa - sb;          bo = (r < 0); end
      5'h03: begin r = ia - ib - int'(bi); sr = sa - sb - int'(bi); bo = (r < 0); end
      5'h04: begin r = ia + 1;           sr = sa + 1;           c = (r > 255); end
      5'h05: begin r = ia - 1;           sr = sa - 1;           bo = (r < 0); end
      5'h06: r = int'(a & b);
      5'h07: r = int'(a | b);
      5'h08: r = int'(a ^ b);
      5'h09: r = 255 - ia;
      5'h0A: r = 255 - int'(a & b);
      5'h0B: r = 255 - int'(a | b);
      5'h0C: r = 255 - int'(a ^ b);
      5'h0D: begin r = (ia * 2) % 256;                       c = (ia >= 128); end
      5'h0E: begin r = ia / 2;                               c = (ia % 2) == 1; end
      5'h0F: begin r = ia / 2 + ((ia >= 128) ? 128 : 0);     c = (ia % 2) == 1; end
      5'h10: begin r = (ia * 2) % 256 + ia / 128;            c = (ia >= 128); end
      5'h11: begin r = ia / 2 + (ia % 2) * 128;              c = (ia % 2) == 1; end
      5'h12: begin r = ia - ib;          sr = sa - sb;          bo = (r < 0); end
      5'h13: r = ia;
      5'h14: r = ib;
      5'h15: begin r = 0 - ia;           sr = 0 - sa;           bo = (r < 0); end
      default: r = 0;
    endcase
    if ((op <= 5'h05) || (op == 5'h12) || (op == 5'h15)) v = (sr > 127) || (sr < -128);
    res = r[7:0];
    shown = (op == 5'h12) ? prev : res;
    return {shown, c, bo, (res == 8'h00), res[7], v};
  endfunction

  // Scoreboard: every result_ready pulse pops and compares one expectation
  always @(negedge clk) begin
    if (rst === 1'b1 && result_ready === 1'b1) begin
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse: result_ready=1 with no launch outstanding, outputs=%h", observed());
      end else begin
        logic [12:0] e;
        e = sb_q.pop_front();
        if (observed() !== e) begin
          errors = errors + 1;
          $display("FAIL scoreboard: got {res,c,b,z,n,v}=%h_%b expected %h_%b",
                   observed() >> 5, observed() & 13'h1F, e >> 5, e & 13'h1F);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic bi);
    logic [12:0] e;
    @(negedge clk);
    opcode = op; operand_A = a; operand_B = b; carry_in = ci; borrow_in = bi;
    input_ready = 1'b1;
    e = model(op, a, b, ci, bi, last_exp[12:5]);
    sb_q.push_back(e);
    last_exp = e;
    @(negedge clk);
    input_ready = 1'b0;
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL launch_timeout: op=%h outstanding=%0d required 0", op, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
    checks = checks + 1;
    if (result_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL pulse_width: op=%h result_ready=%b required 0", op, result_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; input_ready = 1'b0;
    opcode = 5'h00; operand_A = 8'h00; operand_B = 8'h00; carry_in = 1'b0; borrow_in = 1'b0;
    last_exp = '0;
    repeat (2) @(negedge clk);
    checks = checks + 2;
    if (observed() !== 13'h0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: got %h required 0", observed());
    end
    if (result_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_ready: got %b required 0", result_ready);
    end
    rst = 1'b1;
  endtask

  task automatic test_arith();
    issue(5'h00, 8'h7F, 8'h01, 1'b0, 1'b0);
    checks = checks + 1;
    if (result_out !== 8'h80 || negative !== 1'b1 || overflow !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL add_7f_01: res=%h n=%b v=%b required 80 1 1", result_out, negative, overflow);
    end
    issue(5'h00, 8'hFF, 8'h01, 1'b0, 1'b0);
    checks = checks + 1;
    if (result_out !== 8'h00 || carry_out !== 1'b1 || zero !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL add_ff_01: res=%h c=%b z=%b required 00 1 1", result_out, carry_out, zero);
    end
    issue(5'h03, 8'h00, 8'h00, 1'b0, 1'b1);
    checks = checks + 1;
    if (result_out !== 8'hFF || borrow_out !== 1'b1 || negative !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL sbb_00_00: res=%h b=%b n=%b required ff 1 1", result_out, borrow_out, negative);
    end
    issue(5'h01, 8'h80, 8'h7F, 1'b1, 1'b0);
    issue(5'h15, 8'h80, 8'h00, 1'b0, 1'b0);
    issue(5'h05, 8'h80, 8'h00, 1'b0, 1'b0);
    issue(5'h04, 8'h7F, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_shift();
    issue(5'h0D, 8'h81, 8'h00, 1'b0, 1'b0);
    checks = checks + 1;
    if (result_out !== 8'h02 || carry_out !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL shl_81: res=%h c=%b required 02 1", result_out, carry_out);
    end
    issue(5'h0F, 8'h81, 8'h00, 1'b0, 1'b0);
    issue(5'h10, 8'h81, 8'h00, 1'b0, 1'b0);
    issue(5'h11, 8'h01, 8'h00, 1'b0, 1'b0);
    checks = checks + 1;
    if (result_out !== 8'h80 || carry_out !== 1'b1 || negative !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL ror_01: res=%h c=%b n=%b required 80 1 1", result_out, carry_out, negative);
    end
  endtask

  task automatic test_cmp_reserved();
    issue(5'h12, 8'h05, 8'h05, 1'b0, 1'b0);
    checks = checks + 1;
    if (result_out !== 8'h80 || zero !== 1'b1 || borrow_out !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL cmp_hold: res=%h z=%b b=%b required 80 1 0", result_out, zero, borrow_out);
    end
    issue(5'h1F, 8'hAA, 8'h55, 1'b1, 1'b1);
    checks = checks + 1;
    if (observed() !== {8'h00, 5'b00100}) begin
      errors = errors + 1;
      $display("FAIL reserved_1f: got %h required %h", observed(), {8'h00, 5'b00100});
    end
  endtask

  task automatic test_hold_level();
    int pulses;
    logic [12:0] e;
    @(negedge clk);
    opcode = 5'h14; operand_A = 8'h11; operand_B = 8'h3C; input_ready = 1'b1;
    e = model(5'h14, 8'h11, 8'h3C, 1'b0, 1'b0, last_exp[12:5]);
    sb_q.push_back(e);
    last_exp = e;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (result_ready === 1'b1) pulses++;
    end
    input_ready = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (pulses != 1) begin
      errors = errors + 1;
      $display("FAIL hold_level_pulses: got %0d required 1", pulses);
    end
    sb_q.delete();
  endtask

  task automatic test_enable_low();
    int pulses;
    @(negedge clk);
    enable = 1'b0;
    opcode = 5'h00; operand_A = 8'h01; operand_B = 8'h01; input_ready = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (result_ready === 1'b1) pulses++;
    end
    checks = checks + 2;
    if (pulses != 0) begin
      errors = errors + 1;
      $display("FAIL enable_low_pulses: got %0d required 0", pulses);
    end
    if (observed() !== last_exp) begin
      errors = errors + 1;
      $display("FAIL enable_low_hold: got %h required %h", observed(), last_exp);
    end
    input_ready = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    issue(5'h08, 8'hF0, 8'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_reset_launch();
    int pulses;
    @(negedge clk);
    opcode = 5'h00; operand_A = 8'h01; operand_B = 8'h01; input_ready = 1'b1; rst = 1'b0;
    @(negedge clk);
    checks = checks + 2;
    if (observed() !== 13'h0) begin
      errors = errors + 1;
      $display("FAIL reset_launch_outputs: got %h required 0", observed());
    end
    if (result_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_launch_ready: got %b required 0", result_ready);
    end
    last_exp = '0;
    rst = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (result_ready === 1'b1) pulses++;
    end
    checks = checks + 1;
    if (pulses != 0) begin
      errors = errors + 1;
      $display("FAIL held_ready_after_reset: pulses=%0d required 0", pulses);
    end
    input_ready = 1'b0;
    issue(5'h00, 8'h02, 8'h03, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      issue(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: outstanding=%0d required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_cmp_reserved();
    test_hold_level();
    test_enable_low();
    test_reset_launch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
